// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, ID-branch operand, redirect and mul/div
// stalls for the 5-stage MIPS core, sequenced by a small FSM with a stall counter.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UseRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WR_out,
  input  logic             M_MemRead,
  input  logic [4:0]       M_WR_out,
  input  logic             EX_MD_start,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_M_Flush,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] Stall_cnt
);

  localparam int unsigned       MdLoadInt = MD_LAT - 2;
  localparam logic [CNT_W-1:0] MdLoad    = MdLoadInt[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {StRun, StStall, StMdWait} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic match_ex, match_m;
  logic need_two, need_one;

  assign match_ex = (EX_WR_out != 5'd0) &&
                    ((EX_WR_out == ID_Rs) || (ID_UseRt && (EX_WR_out == ID_Rt)));
  assign match_m  = (M_WR_out != 5'd0) &&
                    ((M_WR_out == ID_Rs) || (ID_UseRt && (M_WR_out == ID_Rt)));

  // A branch compared in ID needs a loaded operand two cycles early, an ALU result one.
  assign need_two = ID_Branch && EX_MemRead && match_ex;
  assign need_one = (EX_MemRead && match_ex) ||
                    (ID_Branch && EX_RegWrite && match_ex) ||
                    (ID_Branch && M_MemRead && match_m);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Write = 1'b1;
    ID_EX_Flush = 1'b0;
    EX_M_Flush  = 1'b0;
    MD_Busy     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (EX_MD_start) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Write = 1'b0;
          EX_M_Flush  = 1'b1;
          if (MD_LAT > 2) begin
            state_d = StMdWait;
            cnt_d   = MdLoad;
          end
        end else if (need_two || need_one) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
          if (need_two) begin
            state_d = StStall;
            cnt_d   = CntOne;
          end
        end else begin
          IF_ID_Flush = ID_Jump || (ID_Branch && ID_BranchTaken);
        end
      end
      StStall: begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
        cnt_d       = cnt_q - CntOne;
        if (cnt_q == CntOne) state_d = StRun;
      end
      StMdWait: begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Write = 1'b0;
        EX_M_Flush  = 1'b1;
        MD_Busy     = 1'b1;
        cnt_d       = cnt_q - CntOne;
        if (cnt_q == CntOne) state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Reset wins over any in-flight sequence: outputs show the idle RUN values.
    if (!rst) begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Write = 1'b1;
      ID_EX_Flush = 1'b0;
      EX_M_Flush  = 1'b0;
      MD_Busy     = 1'b0;
    end
  end

  assign Stall_cnt = rst ? cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, a reset-abort sequence
// and randomized cycles against a remaining-bubble reference model.
module tb_hazard_ctrl;
  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNT_W  = 3;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Flush, MD_Busy}
  localparam logic [6:0] DEF    = 7'b1101000;
  localparam logic [6:0] DSTALL = 7'b0001100;
  localparam logic [6:0] MDS    = 7'b0000010;
  localparam logic [6:0] MDW    = 7'b0000011;
  localparam logic [6:0] REDIR  = 7'b1111000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] ID_Rs, ID_Rt, EX_WR_out, M_WR_out;
  logic ID_UseRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic EX_MemRead, EX_RegWrite, M_MemRead, EX_MD_start;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Flush, MD_Busy;
  logic [CNT_W-1:0] Stall_cnt;

  int tests = 0;
  int fails = 0;

  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WR_out(EX_WR_out),
    .M_MemRead(M_MemRead), .M_WR_out(M_WR_out), .EX_MD_start(EX_MD_start),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush), .EX_M_Flush(EX_M_Flush),
    .MD_Busy(MD_Busy), .Stall_cnt(Stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [4:0] rs, rt;
    logic       urt, br, tk, jp, exmr, exrw;
    logic [4:0] exwr;
    logic       mmr;
    logic [4:0] mwr;
    logic       md;
    logic [6:0] e;
    logic [2:0] c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urt, input logic br, input logic tk,
                              input logic jp, input logic exmr, input logic exrw,
                              input logic [4:0] exwr, input logic mmr,
                              input logic [4:0] mwr, input logic md,
                              input logic [6:0] e, input logic [2:0] c);
    vec_t v;
    v.r = r; v.rs = rs; v.rt = rt; v.urt = urt; v.br = br; v.tk = tk; v.jp = jp;
    v.exmr = exmr; v.exrw = exrw; v.exwr = exwr; v.mmr = mmr; v.mwr = mwr; v.md = md;
    v.e = e; v.c = c;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.r; ID_Rs = v.rs; ID_Rt = v.rt; ID_UseRt = v.urt; ID_Branch = v.br;
    ID_BranchTaken = v.tk; ID_Jump = v.jp; EX_MemRead = v.exmr; EX_RegWrite = v.exrw;
    EX_WR_out = v.exwr; M_MemRead = v.mmr; M_WR_out = v.mwr; EX_MD_start = v.md;
  endtask

  task automatic check(input string name, input logic [6:0] e, input logic [2:0] c);
    logic [6:0] a;
    a = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Flush, MD_Busy};
    tests++;
    if (a !== e || Stall_cnt !== c) begin
      fails++;
      $display("FAIL %s: got out=%b cnt=%0d, want out=%b cnt=%0d", name, a, Stall_cnt, e, c);
    end
  endtask

  function automatic int match(input logic [4:0] r, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt);
    return ((r != 0) && (r == rs || (urt && r == rt))) ? 1 : 0;
  endfunction

  function automatic int bubbles(input vec_t v);
    int mex, mm;
    mex = match(v.exwr, v.rs, v.rt, v.urt);
    mm  = match(v.mwr, v.rs, v.rt, v.urt);
    if (v.br && v.exmr && mex != 0) return 2;
    if (v.exmr && mex != 0) return 1;
    if (v.br && v.exrw && mex != 0) return 1;
    if (v.br && v.mmr && mm != 0) return 1;
    return 0;
  endfunction

  initial begin
    vec_t v;
    int md_rem, st_rem, n;
    logic [6:0] e;
    logic [2:0] c;

    //         r  rs rt u br tk jp exmr exrw exwr mmr mwr md exp    cnt
    tbl.push_back(mk(0, 8, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 1, DEF,    0)); // rst forces defaults
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, DEF,    0));
    tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, DSTALL, 0)); // load-use
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,    0));
    tbl.push_back(mk(1, 3, 8, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, DEF,    0)); // rt unused
    tbl.push_back(mk(1, 0, 9, 1, 1, 0, 0, 1, 0, 9, 0, 0, 0, DSTALL, 0)); // branch after load
    tbl.push_back(mk(1, 0, 9, 1, 1, 0, 0, 1, 0, 9, 0, 0, 0, DSTALL, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,    0));
    tbl.push_back(mk(1,10, 0, 0, 1, 0, 0, 0, 1,10, 0, 0, 0, DSTALL, 0)); // branch after ALU
    tbl.push_back(mk(1,10, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, REDIR,  0)); // taken, no hazard
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,    0));
    tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 1, MDS,    0)); // md over load-use
    tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, MDW,    2));
    tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, MDW,    1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,    0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, DEF,    0)); // $0 never stalls
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, REDIR,  0)); // jump
    tbl.push_back(mk(1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 5, 0, DSTALL, 0)); // branch after load in MEM
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, MDS,    0)); // md over redirect
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDW,    2)); // md start ignored
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MDW,    1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,    0));
    tbl.push_back(mk(1, 4, 0, 0, 1, 0, 0, 1, 0, 4, 0, 0, 0, DSTALL, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DSTALL, 1)); // md in STALL ignored
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,    0));

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check($sformatf("vec%0d", i), tbl[i].e, tbl[i].c);
    end

    // Reset in the second MD_WAIT cycle aborts with no leftover bubble.
    @(negedge clk); apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 0)); #1;
    check("rstmd_start", MDS, 0);
    @(negedge clk); apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0)); #1;
    check("rstmd_wait1", MDW, 2);
    @(negedge clk); apply(mk(0, 8, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 1, DEF, 0)); #1;
    check("rstmd_low", DEF, 0);
    @(negedge clk); apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0)); #1;
    check("rstmd_after", DEF, 0);
    @(negedge clk); apply(mk(1, 8, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, DEF, 0)); #1;
    check("rstmd_loaduse", DSTALL, 0);
    @(negedge clk); apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0)); #1;
    check("rstmd_idle", DEF, 0);

    // Random phase: the model tracks only how many frozen cycles remain.
    md_rem = 0;
    st_rem = 0;
    for (int k = 0; k < 400; k++) begin
      v = mk($urandom_range(0, 19) != 0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
             DEF, 0);
      if (!v.r) begin
        e = DEF; c = 0; md_rem = 0; st_rem = 0;
      end else if (md_rem > 0) begin
        e = MDW; c = 3'(md_rem); md_rem--;
      end else if (st_rem > 0) begin
        e = DSTALL; c = 3'(st_rem); st_rem--;
      end else begin
        n = bubbles(v);
        c = 0;
        if (v.md) begin
          e = MDS; md_rem = MD_LAT - 2;
        end else if (n > 0) begin
          e = DSTALL; st_rem = n - 1;
        end else if (v.jp || (v.br && v.tk)) begin
          e = REDIR;
        end else begin
          e = DEF;
        end
      end
      @(negedge clk);
      apply(v);
      #1;
      check($sformatf("rand%0d", k), e, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; it sits beside the EX-stage forwarding unit and sequences the front end.
- It covers hazards forwarding cannot fix: load-use, branch operands resolved in ID, taken branch/jump redirect, and a multi-cycle mul/div unit occupying EX.
- It drives the PC and pipeline-register write enables and flushes through a small FSM with a stall counter.

Parameters:
- MD_LAT, 4, cycles a mul/div occupies EX (legal range 2..2^CNT_W).
- CNT_W, 3, stall counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_UseRt  in  1  ID instruction reads rt as a source
- ID_Branch  in  1  ID instruction is beq/bne (compare in ID)
- ID_BranchTaken  in  1  branch comparator result in ID
- ID_Jump  in  1  ID instruction is j/jal/jr
- EX_MemRead  in  1  EX instruction is a load
- EX_RegWrite  in  1  EX instruction writes a register
- EX_WR_out  in  5  destination register of EX instruction
- M_MemRead  in  1  MEM instruction is a load
- M_WR_out  in  5  destination register of MEM instruction
- EX_MD_start  in  1  mul/div entering EX this cycle
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  zero IF/ID (squash fetched instruction)
- ID_EX_Write  out  1  ID/EX register enable
- ID_EX_Flush  out  1  insert bubble into ID/EX
- EX_M_Flush  out  1  insert bubble into EX/MEM
- MD_Busy  out  1  FSM in MD_WAIT
- Stall_cnt  out  CNT_W  remaining stall cycles (debug)

Behaviour:
- Match(r) = (r != 0) && (r == ID_Rs || (ID_UseRt && r == ID_Rt)).
- FSM states: RUN, STALL, MD_WAIT. The register file bypasses internally, so WB needs no stall.
- In RUN, compute the required bubble count n:
  - n = 2 if ID_Branch && EX_MemRead && Match(EX_WR_out).
  - else n = 1 if EX_MemRead && Match(EX_WR_out) (load-use).
  - else n = 1 if ID_Branch && EX_RegWrite && Match(EX_WR_out).
  - else n = 1 if ID_Branch && M_MemRead && Match(M_WR_out).
  - else n = 0.
- Data stall (n > 0): same cycle, PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1. If n = 2, load Stall_cnt = 1 and go to STALL; else stay in RUN.
- STALL: hold the same outputs as a data stall, decrement Stall_cnt each cycle, return to RUN after the cycle in which Stall_cnt = 1. Total bubbles equal n exactly.
- MD start: EX_MD_start in RUN (highest priority, overrides n):
  - That cycle: PC_Write = 0, IF_ID_Write = 0, ID_EX_Write = 0, EX_M_Flush = 1.
  - Load Stall_cnt = MD_LAT-2 and go to MD_WAIT; if MD_LAT = 2, stay in RUN.
- MD_WAIT: same outputs as MD start, MD_Busy = 1, decrement Stall_cnt. Exit to RUN after the cycle in which Stall_cnt = 1. The front end is frozen for exactly MD_LAT-1 cycles.
- Redirect: in RUN with n = 0 and no EX_MD_start, IF_ID_Flush = ID_Jump || (ID_Branch && ID_BranchTaken) for one cycle. PC_Write stays 1.
- Priority: MD > data stall > redirect. A suppressed branch is re-evaluated after the stall because IF/ID is held.
- EX_MD_start while in STALL or MD_WAIT is ignored (illegal in a correct pipeline).
- Default outputs in RUN with no event: PC_Write = IF_ID_Write = ID_EX_Write = 1, all flushes 0, MD_Busy = 0, Stall_cnt = 0.
- Reset: while rst = 0 at a clk edge, state goes to RUN and Stall_cnt to 0. While rst is low, outputs are forced to the RUN defaults regardless of inputs. Reset mid-STALL or mid-MD_WAIT aborts the sequence with no residual bubble.
- Stall_cnt never wraps; a decrement at 0 is impossible by construction.

Test Plan:
- Load-use: EX_MemRead = 1, EX_WR_out = 8, ID_Rs = 8 -> exactly one cycle of PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1, then defaults. Same stimulus with ID_Rt = 8, ID_UseRt = 0 -> no stall.
- Branch after load: ID_Branch = 1, EX_MemRead = 1, EX_WR_out = 9 = ID_Rt, ID_UseRt = 1 -> 2 consecutive stall cycles (STALL entered with Stall_cnt = 1), then RUN.
- Branch after ALU op: ID_Branch = 1, EX_RegWrite = 1, EX_WR_out = 10 = ID_Rs -> 1 bubble. Next cycle ID_BranchTaken = 1 with no hazard -> IF_ID_Flush = 1 for one cycle.
- Mul/div, MD_LAT = 4: EX_MD_start = 1 while a load-use is also present -> 3 cycles of PC_Write = 0, ID_EX_Write = 0, EX_M_Flush = 1, MD_Busy = 1 for the 2 MD_WAIT cycles. The load-use stall is not applied during those 3 cycles.
- Register $0: EX_MemRead = 1, EX_WR_out = 0 = ID_Rs -> no stall.
- Reset mid-MD_WAIT: rst = 0 at the second MD_WAIT cycle -> next edge RUN, Stall_cnt = 0, outputs at defaults while rst is low and after release.
